// File: rtl/reorder_buffer_pkg.sv
// Shared constants and types for the reorder buffer.
// Tag 0 is reserved as NULL_TAG ("register not renamed"), so a buffer with
// REORDER_BUFFER_SIZE_LOG tag bits holds 2^LOG - 1 usable entries (tags 1..2^LOG-1).
package reorder_buffer_pkg;

  localparam int REGISTER_NUMBER_LOG     = 5;
  localparam int REORDER_BUFFER_SIZE_LOG = 3;
  localparam int DATA_WIDTH              = 32;

  // Storage is indexed directly by tag; slot 0 exists but is never allocated.
  localparam int ROB_DEPTH = 1 << REORDER_BUFFER_SIZE_LOG;

  localparam logic [REORDER_BUFFER_SIZE_LOG-1:0] NULL_TAG    = '0;
  // All-ones in the tag width equals 2^LOG - 1, the usable entry count.
  localparam logic [REORDER_BUFFER_SIZE_LOG-1:0] ROB_ENTRIES = '1;

  typedef logic [REORDER_BUFFER_SIZE_LOG-1:0] rob_tag_t;
  typedef logic [REGISTER_NUMBER_LOG-1:0]     reg_idx_t;
  typedef logic [DATA_WIDTH-1:0]              rob_data_t;

  typedef struct packed {
    logic      ready;
    rob_data_t value;
  } query_result_t;

  // Operand lookup for one tag. A CDB broadcast for the same tag wins over the
  // stored value, so a consumer issuing in the writeback cycle sees the result.
  function automatic query_result_t lookup(
    input rob_tag_t  tag,
    input logic      busy,
    input logic      done,
    input rob_data_t stored,
    input logic      wb_valid,
    input rob_tag_t  wb_tag,
    input rob_data_t wb_value
  );
    query_result_t r;
    r.ready = 1'b0;
    r.value = '0;
    if (tag != NULL_TAG && busy) begin
      if (wb_valid && wb_tag == tag) begin
        r.ready = 1'b1;
        r.value = wb_value;
      end else if (done) begin
        r.ready = 1'b1;
        r.value = stored;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/reorder_buffer_pointer.sv
// Head/tail pointer for the reorder buffer.
// Counts 1..2^WIDTH-1 and wraps back to 1, never producing the reserved tag 0.
// Ports:
//   clk     in  rising-edge clock
//   reset   in  asynchronous active-low reset (pointer -> 1)
//   flush   in  synchronous return to 1, overrides advance
//   advance in  step to the next tag
//   ptr     out current pointer value
module reorder_buffer_pointer #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             advance,
  output logic [WIDTH-1:0] ptr
);

  localparam logic [WIDTH-1:0] FIRST = WIDTH'(1);
  localparam logic [WIDTH-1:0] LAST  = '1;

  logic [WIDTH-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (flush) begin
      ptr_d = FIRST;
    end else if (advance) begin
      ptr_d = (ptr_q == LAST) ? FIRST : ptr_q + FIRST;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q <= FIRST;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/reorder_buffer.sv
// In-order retirement buffer for the Tomasulo core.
// Allocates tags at the tail for issue, captures CDB results, answers operand
// lookups by tag (with CDB bypass), and retires one done entry per cycle from
// the head through registered commit outputs.
// Ports:
//   clk, reset (async active-low), flush (sync squash of everything)
//   issueValid/issueDest      -> issueReady, issueTag (tag to allocate = tail)
//   wbValid/wbTag/wbValue     CDB broadcast
//   queryTagA/B               -> queryReadyA/B, queryValueA/B (combinational)
//   commitValid/Tag/Dest/Value registered retirement info
//   count                     occupied entries
module reorder_buffer
  import reorder_buffer_pkg::*;
(
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               flush,
  input  logic                               issueValid,
  input  logic [REGISTER_NUMBER_LOG-1:0]     issueDest,
  output logic                               issueReady,
  output logic [REORDER_BUFFER_SIZE_LOG-1:0] issueTag,
  input  logic                               wbValid,
  input  logic [REORDER_BUFFER_SIZE_LOG-1:0] wbTag,
  input  logic [DATA_WIDTH-1:0]              wbValue,
  input  logic [REORDER_BUFFER_SIZE_LOG-1:0] queryTagA,
  input  logic [REORDER_BUFFER_SIZE_LOG-1:0] queryTagB,
  output logic                               queryReadyA,
  output logic                               queryReadyB,
  output logic [DATA_WIDTH-1:0]              queryValueA,
  output logic [DATA_WIDTH-1:0]              queryValueB,
  output logic                               commitValid,
  output logic [REORDER_BUFFER_SIZE_LOG-1:0] commitTag,
  output logic [REGISTER_NUMBER_LOG-1:0]     commitDest,
  output logic [DATA_WIDTH-1:0]              commitValue,
  output logic [REORDER_BUFFER_SIZE_LOG-1:0] count
);

  logic [ROB_DEPTH-1:0] busy_q, busy_d;
  logic [ROB_DEPTH-1:0] done_q, done_d;
  reg_idx_t             dest_q  [ROB_DEPTH];
  reg_idx_t             dest_d  [ROB_DEPTH];
  rob_data_t            value_q [ROB_DEPTH];
  rob_data_t            value_d [ROB_DEPTH];

  rob_tag_t  head, tail;
  rob_tag_t  count_q, count_d;

  logic      commit_valid_q, commit_valid_d;
  rob_tag_t  commit_tag_q, commit_tag_d;
  reg_idx_t  commit_dest_q, commit_dest_d;
  rob_data_t commit_value_q, commit_value_d;

  logic issue_fire, wb_fire, commit_fire;

  // Readiness comes from the registered count, so a full buffer cannot reuse
  // the slot it is retiring in the same cycle.
  assign issue_fire  = issueValid && issueReady;
  assign wb_fire     = wbValid && (wbTag != NULL_TAG) && busy_q[wbTag];
  // Retirement looks only at stored done bits; a writeback landing on the
  // head this cycle is visible one edge later.
  assign commit_fire = busy_q[head] && done_q[head];

  reorder_buffer_pointer #(.WIDTH(REORDER_BUFFER_SIZE_LOG)) u_head_ptr (
    .clk     (clk),
    .reset   (reset),
    .flush   (flush),
    .advance (commit_fire),
    .ptr     (head)
  );

  reorder_buffer_pointer #(.WIDTH(REORDER_BUFFER_SIZE_LOG)) u_tail_ptr (
    .clk     (clk),
    .reset   (reset),
    .flush   (flush),
    .advance (issue_fire),
    .ptr     (tail)
  );

  // Entry state. Later statements override earlier ones: commit frees the
  // head after any writeback to it, and issue claims the (idle) tail slot.
  // NOTE: blocking '=' in always_comb gives this in-order override semantics;
  // every _d signal is defaulted first so no latch is inferred.
  always_comb begin
    busy_d  = busy_q;
    done_d  = done_q;
    dest_d  = dest_q;
    value_d = value_q;
    if (flush) begin
      busy_d = '0;
      done_d = '0;
    end else begin
      if (wb_fire) begin
        done_d[wbTag]  = 1'b1;
        value_d[wbTag] = wbValue;
      end
      if (commit_fire) begin
        busy_d[head] = 1'b0;
        done_d[head] = 1'b0;
      end
      if (issue_fire) begin
        busy_d[tail] = 1'b1;
        done_d[tail] = 1'b0;
        dest_d[tail] = issueDest;
      end
    end
  end

  always_comb begin
    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else begin
      count_d = count_q + REORDER_BUFFER_SIZE_LOG'(issue_fire)
                        - REORDER_BUFFER_SIZE_LOG'(commit_fire);
    end
  end

  // Commit outputs hold their last payload when nothing retires.
  always_comb begin
    commit_valid_d = 1'b0;
    commit_tag_d   = commit_tag_q;
    commit_dest_d  = commit_dest_q;
    commit_value_d = commit_value_q;
    if (!flush && commit_fire) begin
      commit_valid_d = 1'b1;
      commit_tag_d   = head;
      commit_dest_d  = dest_q[head];
      commit_value_d = value_q[head];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_q         <= '0;
      done_q         <= '0;
      count_q        <= '0;
      commit_valid_q <= 1'b0;
      commit_tag_q   <= '0;
      commit_dest_q  <= '0;
      commit_value_q <= '0;
    end else begin
      busy_q         <= busy_d;
      done_q         <= done_d;
      count_q        <= count_d;
      commit_valid_q <= commit_valid_d;
      commit_tag_q   <= commit_tag_d;
      commit_dest_q  <= commit_dest_d;
      commit_value_q <= commit_value_d;
    end
  end

  // NOTE: payload arrays are deliberately not reset; they are only observed
  // through busy/done, which are reset, so resetting them would buy nothing.
  always_ff @(posedge clk) begin
    dest_q  <= dest_d;
    value_q <= value_d;
  end

  query_result_t query_a, query_b;

  always_comb begin
    query_a = lookup(queryTagA, busy_q[queryTagA], done_q[queryTagA],
                     value_q[queryTagA], wbValid, wbTag, wbValue);
    query_b = lookup(queryTagB, busy_q[queryTagB], done_q[queryTagB],
                     value_q[queryTagB], wbValid, wbTag, wbValue);
  end

  assign issueReady  = (count_q < ROB_ENTRIES);
  assign issueTag    = tail;
  assign queryReadyA = query_a.ready;
  assign queryValueA = query_a.value;
  assign queryReadyB = query_b.ready;
  assign queryValueB = query_b.value;
  assign commitValid = commit_valid_q;
  assign commitTag   = commit_tag_q;
  assign commitDest  = commit_dest_q;
  assign commitValue = commit_value_q;
  assign count       = count_q;

endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
- In-order retirement buffer for the Tomasulo core.
- Allocates the reorder-buffer tag that issue writes into the register status table.
- Captures results from the common data bus and answers operand lookups by tag.
- Retires entries in program order, emitting commit info so the register file is written and the status-table entry is released (status table clears only if its entry still equals commitTag).

Parameters:
- REGISTER_NUMBER_LOG, 5, log2 of architectural register count.
- REORDER_BUFFER_SIZE_LOG, 3, tag width; tag 0 is reserved (NULL_TAG = "not renamed"), so usable entries = 2^LOG - 1.
- DATA_WIDTH, 32, result width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous squash of all entries (mispredict).
- issueValid  in  1  issue requests an entry.
- issueDest  in  REGISTER_NUMBER_LOG  destination register of issuing instruction.
- issueReady  out  1  entry available (registered count < 2^LOG-1).
- issueTag  out  REORDER_BUFFER_SIZE_LOG  tag to be allocated (= tail), valid when issueReady.
- wbValid  in  1  CDB broadcast.
- wbTag  in  REORDER_BUFFER_SIZE_LOG  producing tag.
- wbValue  in  DATA_WIDTH  result.
- queryTagA, queryTagB  in  REORDER_BUFFER_SIZE_LOG  operand tags from status-table readValueA/B.
- queryReadyA, queryReadyB  out  1  result available for that tag.
- queryValueA, queryValueB  out  DATA_WIDTH  result; 0 when not ready.
- commitValid  out  1  one entry retired this cycle.
- commitTag  out  REORDER_BUFFER_SIZE_LOG  retired tag.
- commitDest  out  REGISTER_NUMBER_LOG  retired destination.
- commitValue  out  DATA_WIDTH  retired result.
- count  out  REORDER_BUFFER_SIZE_LOG  occupied entries.

Behaviour:
- Per-entry state: busy, done, dest, value. Pointers head/tail range 1..2^LOG-1; increment wraps 2^LOG-1 -> 1, never 0.
- Reset (reset=0, async): all busy/done=0; head=tail=1; count=0; commitValid=0; commitTag/Dest/Value=0.
- Issue: at posedge, if issueValid && issueReady: entry[tail] <= busy=1, done=0, dest=issueDest; tail++. issueValid while !issueReady is ignored, with no state change.
- Writeback: at posedge, if wbValid && entry[wbTag].busy: done=1, value=wbValue. Writeback to tag 0 or a non-busy entry is ignored. A repeat writeback overwrites value.
- Commit (registered outputs): at posedge, if entry[head].busy && done: commitValid<=1, commitTag<=head, commitDest/Value<=entry fields; entry freed; head++. Otherwise commitValid<=0 (other commit outputs hold). At most one commit per cycle.
- Latency: writeback at edge N -> commit at edge N+1 at the earliest (commitValid high after N+1).
- Simultaneous issue+commit: both occur; count unchanged. issueReady uses pre-edge count, so a full buffer does not accept issue in the cycle it commits.
- Writeback to head in the same cycle as commit evaluation: not seen until next edge.
- Query (combinational):
  - ready = (tag!=0) && ((busy && done) || (wbValid && wbTag==tag && busy)). The CDB bypass has priority over stored value.
  - tag 0 -> ready=0, value=0.
- Flush: synchronous; priority over issue/wb/commit in the same cycle. All entries cleared; head=tail=1; count=0; commitValid<=0.
- count = entries busy; max 2^LOG-1.

Decomposition:
- Shared include (with existing utility constants): REGISTER_NUMBER_LOG, REORDER_BUFFER_SIZE_LOG, DATA_WIDTH, NULL_TAG=0, ROB_ENTRIES=2^LOG-1.
- One sub-module: reorder_buffer_pointer. Registered head/tail pointer with async active-low reset to 1, increment-with-skip-zero wrap, and synchronous flush to 1. Instantiated twice.

Test Plan (LOG=3, 7 entries):
- Reset low mid-run -> immediately count=0, commitValid=0, issueTag=1, issueReady=1.
- Issue dest 2,3,4 on three cycles -> issueTag 1,2,3; count=3. Writeback tag2=0xAA first, then tag1=0x55 -> commits in order: (tag1,r2,0x55) then (tag2,r3,0xAA), one cycle each.
- Issue 7 without writeback -> issueReady=0, count=7, 8th issue ignored. Commit head, then issue again -> issueTag wraps 7->1 (never 0).
- queryTagA=3 while wbValid, wbTag=3, wbValue=0x12 -> queryReadyA=1, queryValueA=0x12 same cycle. queryTagB=0 -> ready 0, value 0.
- Full buffer, head done, issueValid=1 same cycle -> commit occurs, issue rejected, count=6. Next cycle issue accepted.
- flush with issueValid, wbValid and a done head asserted together -> count=0, commitValid=0, issueTag=1 next cycle.
